// File: rtl/spi_adc_pkg.sv
// Shared types and sizing helpers for the SPI ADC controller.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StQuiet
  } state_e;

  function automatic int unsigned frame_len(input int unsigned lead, input int unsigned data,
                                            input int unsigned trail);
    return lead + data + trail;
  endfunction

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_adc_ctrl_if.sv
// Three-wire ADC link: chip select and serial clock from the controller, data back.
interface spi_adc_ctrl_if;
  logic cs_n;
  logic sclk;
  logic sdata;

  modport master (
    output cs_n,
    output sclk,
    input  sdata
  );

  modport slave (
    input  cs_n,
    input  sclk,
    output sdata
  );
endinterface

// File: rtl/spi_adc_avg.sv
// Accumulates 2**AVG_LOG2 raw frames, then publishes the truncated mean and the
// OR of the per-frame zero-bit errors.
module spi_adc_avg #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_err,
  input  logic              sample_stb,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              result_err,
  output logic              group_open
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned FRM_W = AVG_LOG2 + 1;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sum;
  logic [FRM_W-1:0]  frm_q;
  logic              err_acc_q;
  logic              last;
  logic [DATA_W-1:0] result_q;
  logic              valid_q;
  logic              err_q;

  assign sum  = acc_q + ACC_W'(sample);
  assign last = (frm_q == FRM_W'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q     <= '0;
      frm_q     <= '0;
      err_acc_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (sample_stb) begin
        if (last) begin
          result_q  <= DATA_W'(sum >> AVG_LOG2);
          valid_q   <= 1'b1;
          err_q     <= err_acc_q | sample_err;
          acc_q     <= '0;
          frm_q     <= '0;
          err_acc_q <= 1'b0;
        end else begin
          acc_q     <= sum;
          frm_q     <= frm_q + 1'b1;
          err_acc_q <= err_acc_q | sample_err;
        end
      end
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign result_err   = err_q;
  assign group_open   = (frm_q != '0);

endmodule

// File: rtl/spi_adc_ctrl.sv
// SPI ADC frame controller: generates cs_n/sclk, deserialises each frame, checks the
// zero padding and hands raw samples to the averager.
module spi_adc_ctrl
  import spi_adc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LEAD_ZEROS  = 3,
  parameter int unsigned TRAIL_ZEROS = 4,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned QUIET_CYC   = 16,
  parameter int unsigned AVG_LOG2    = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              cont,
  spi_adc_ctrl_if.master    spi,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned FRAME_LEN = frame_len(LEAD_ZEROS, DATA_W, TRAIL_ZEROS);
  localparam int unsigned CNT_MAX   = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int unsigned CNT_W     = cnt_w(CNT_MAX);
  localparam int unsigned BIT_W     = cnt_w(FRAME_LEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              start_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ferr_q, ferr_d;
  logic              half_end, quiet_end, last_bit, in_data;
  logic              frame_done, group_open;

  assign half_end  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign quiet_end = (cnt_q == CNT_W'(QUIET_CYC - 1));
  assign last_bit  = (bit_q == BIT_W'(FRAME_LEN - 1));
  assign in_data   = (int'(bit_q) >= int'(LEAD_ZEROS)) &&
                     (int'(bit_q) < int'(LEAD_ZEROS + DATA_W));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    shreg_d    = shreg_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_q && !start) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (half_end) begin
          state_d = StShift;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          ferr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (!half_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising sclk edge: sdata has been stable since the preceding falling edge.
            sclk_d = 1'b1;
            if (in_data) begin
              shreg_d = {shreg_q[DATA_W-2:0], spi.sdata};
            end else if (spi.sdata) begin
              ferr_d = 1'b1;
            end
          end else if (last_bit) begin
            state_d    = StQuiet;
            cs_n_d     = 1'b1;
            frame_done = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      StQuiet: begin
        if (quiet_end) begin
          cnt_d = '0;
          // A partially filled average keeps going even in single-shot mode.
          if (cont || group_open) begin
            state_d = StSetup;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      start_q <= 1'b1;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      start_q <= start;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
    end
  end

  spi_adc_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample       (shreg_q),
    .sample_err   (ferr_q),
    .sample_stb   (frame_done),
    .result       (data),
    .result_valid (data_valid),
    .result_err   (frame_err),
    .group_open   (group_open)
  );

  assign spi.cs_n = cs_n_q;
  assign spi.sclk = sclk_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: doc/spi_adc_ctrl.md
SPI_ADC_CTRL -- requirements
Module: spi_adc_ctrl

Interface
REQ-001 SHALL expose parameter DATA_W, default 8, number of ADC data bits per frame.
REQ-002 SHALL expose parameter LEAD_ZEROS, default 3, zero bits the ADC sends before the MSB.
REQ-003 SHALL expose parameter TRAIL_ZEROS, default 4, zero bits the ADC sends after the LSB.
REQ-004 SHALL expose parameter CLK_DIV, default 4 (min 2), clk cycles per sclk half-period.
REQ-005 SHALL expose parameter QUIET_CYC, default 16, minimum clk cycles cs_n stays high between frames.
REQ-006 SHALL expose parameter AVG_LOG2, default 0 (range 0..4), log2 of the number of samples averaged per result.
REQ-007 clk  input  1  system clock; one clock domain only.
REQ-008 n_rst  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  active-low conversion request, sampled synchronously.
REQ-010 cont  input  1  1 = continuous conversion, 0 = single-shot.
REQ-011 sdata  input  1  ADC serial data, MSB first.
REQ-012 cs_n  output  1  ADC chip select, active-low.
REQ-013 sclk  output  1  ADC serial clock, idles high.
REQ-014 data  output  DATA_W  last averaged result.
REQ-015 data_valid  output  1  one-clk pulse when data updates.
REQ-016 frame_err  output  1  one-clk pulse, with data_valid, when any leading- or trailing-zero bit sampled as 1.
REQ-017 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 FRAME_LEN SHALL equal LEAD_ZEROS+DATA_W+TRAIL_ZEROS (15 at defaults).
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT, QUIET.
REQ-020 IDLE->SETUP SHALL occur on the clk after start is sampled 1->0 (falling-edge detect); start held low SHALL NOT retrigger.
REQ-021 SETUP SHALL drive cs_n=0 and sclk=1 for CLK_DIV clks, then enter SHIFT.
REQ-022 SHIFT SHALL generate FRAME_LEN sclk periods, each CLK_DIV clks low then CLK_DIV clks high.
REQ-023 sdata SHALL be sampled on the clk edge where sclk goes 0->1; sample k (0-based) maps to bit DATA_W-1-(k-LEAD_ZEROS) for LEAD_ZEROS<=k<LEAD_ZEROS+DATA_W.
REQ-024 After the last high half-period, cs_n SHALL return to 1 and the FSM SHALL enter QUIET for QUIET_CYC clks.
REQ-025 QUIET exit: cont=1 SHALL go to SETUP; cont=0 SHALL go to IDLE.
REQ-026 cont is sampled only at QUIET exit; clearing it mid-frame SHALL finish the current frame.
REQ-027 start edges while busy=1 SHALL be ignored, not queued.
REQ-028 Averaging: raw samples SHALL accumulate in a DATA_W+AVG_LOG2 bit unsigned accumulator; after 2**AVG_LOG2 frames data SHALL load accumulator>>AVG_LOG2 (truncation) and the accumulator SHALL clear.
REQ-029 AVG_LOG2=0 SHALL update data every frame.
REQ-030 data_valid SHALL pulse on the clk cs_n returns to 1 in the frame completing an average; data holds otherwise.
REQ-031 frame_err SHALL aggregate over the averaged frames and pulse with data_valid; data SHALL still update.
REQ-032 Single-shot with AVG_LOG2>0 SHALL run 2**AVG_LOG2 back-to-back frames (with QUIET gaps) per start edge.
REQ-033 cs_n low time per frame SHALL be exactly CLK_DIV*(1+2*FRAME_LEN) clks.

Reset
REQ-034 n_rst=0 SHALL asynchronously force cs_n=1, sclk=1, data=0, data_valid=0, frame_err=0, busy=0, FSM=IDLE, accumulator/counters=0, start-edge register=1.
REQ-035 Reset mid-frame SHALL abort the frame with no data_valid; first conversion after release requires a new start edge.

Structure
REQ-036 Package spi_adc_pkg SHALL hold the FSM state type and the FRAME_LEN and counter-width constant functions.
REQ-037 Averaging SHALL be one sub-module, spi_adc_avg (sample in/strobe, result/valid/err out).

Verification
REQ-038 Defaults, ADC model shifts 000_1001_0011_0000 on sclk falling; start low pulse -> one data_valid, data=0x93, frame_err=0, cs_n low 124 clks.
REQ-039 Second single-shot with 0x3A -> data=0x3A, cs_n high between frames >= QUIET_CYC, one pulse only.
REQ-040 cont=1, model returns 0x10,0x20,0x30 -> three data_valid pulses in order, cs_n gap exactly 16 clks; clear cont in frame 3 -> IDLE after frame 3.
REQ-041 AVG_LOG2=2, samples 0x10,0x11,0x12,0x13 -> single data_valid with data=0x11.
REQ-042 Model drives 1 on leading bit 1, data 0x55 -> data=0x55 with frame_err pulse.
REQ-043 n_rst low at sclk period 7 -> cs_n=1, sclk=1 same cycle, no data_valid; start edge while busy ignored.
